// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if
// Raster timing bundle produced by vga_sync_gen and consumed by the object
// renderers and the colour output stage.
//
// Signals (all driven by the generator, all registered):
//   hsp[9:0]     horizontal scan position
//   vsp[9:0]     vertical scan position
//   hsync        horizontal sync, active low
//   vsync        vertical sync, active low
//   video_on     (hsp,vsp) lies in the visible area
//   pix_tick     the rising edge that ends this clk advances the position
//   line_start   one-clk pulse after hsp wrapped to 0
//   frame_start  one-clk pulse after (hsp,vsp) wrapped to (0,0)
//
// Modports:
//   master - the timing generator (drives everything)
//   slave  - renderers / output stage (observe everything)
//
// Flow qualification: there is no back-pressure. A position is "presented"
// on every clk and is new on the clk after an edge that had pix_tick=1.
// Consumers may not stall the raster.
`timescale 1ns/1ps
interface vga_sync_gen_if;
    logic [9:0] hsp;
    logic [9:0] vsp;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       pix_tick;
    logic       line_start;
    logic       frame_start;

    modport master (
        output hsp, vsp, hsync, vsync, video_on, pix_tick, line_start, frame_start
    );

    modport slave (
        input hsp, vsp, hsync, vsync, video_on, pix_tick, line_start, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// Raster timing generator for the 640x480 @ 60 Hz display path. Produces the
// scan position, active-low sync pins, the visible-area qualifier and
// line/frame start pulses. Single timing source for the frame.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous, active-low reset
//   vga    master modport of vga_sync_gen_if (see that file for signals)
//
// Configuration:
//   VGA_SYNC_PIXEL_DIV_EN  defined   -> internal phase bit divides clk by 2,
//                                       position advances on every second clk
//                          undefined -> position advances on every clk,
//                                       clk is the pixel clock
//
// Geometry parameters default to 640x480 @ 60 Hz; totals must stay <= 1024
// so the 10-bit counters never overflow.
`timescale 1ns/1ps
module vga_sync_gen #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic           clk,
    input  logic           rst_n,
    vga_sync_gen_if.master vga
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_L    = 10'(H_VIS);
    localparam logic [9:0] V_VIS_L    = 10'(V_VIS);
    localparam logic [9:0] HS_FIRST   = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_VIS + V_FP + V_SYNC - 1);

    // Registered state; these drive the interface directly.
    logic [9:0] hsp_q;
    logic [9:0] vsp_q;
    logic       hsync_q;
    logic       vsync_q;
    logic       video_on_q;
    logic       pix_q;
    logic       line_q;
    logic       frame_q;

    // Next-state signals.
    logic [9:0] hsp_n;
    logic [9:0] vsp_n;
    logic       line_n;
    logic       frame_n;
    logic       adv;

`ifdef VGA_SYNC_PIXEL_DIV_EN
    // pix_q doubles as the divider phase: the edge that ends a clk with
    // phase=1 is the one that advances the position.
    assign adv = pix_q;
`else
    // clk is the pixel clock; every edge out of reset advances, so hsp reads
    // 0,1,2,... on consecutive clks starting with the last reset clk.
    assign adv = 1'b1;
`endif

    always_comb begin
        hsp_n   = hsp_q;
        vsp_n   = vsp_q;
        line_n  = 1'b0;
        frame_n = 1'b0;
        if (adv) begin
            if (hsp_q == H_LAST) begin
                hsp_n  = 10'd0;
                line_n = 1'b1;
                if (vsp_q == V_LAST) begin
                    vsp_n   = 10'd0;
                    frame_n = 1'b1;
                end else begin
                    vsp_n = vsp_q + 10'd1;
                end
            end else begin
                hsp_n = hsp_q + 10'd1;
            end
        end
    end

    // Decode is taken from the next-state counters so the registered sync and
    // blanking flags line up with the position registered on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsp_q      <= 10'd0;
            vsp_q      <= 10'd0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b1;
            pix_q      <= 1'b0;
            line_q     <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            hsp_q      <= hsp_n;
            vsp_q      <= vsp_n;
            hsync_q    <= !((hsp_n >= HS_FIRST) && (hsp_n <= HS_LAST));
            vsync_q    <= !((vsp_n >= VS_FIRST) && (vsp_n <= VS_LAST));
            video_on_q <= (hsp_n < H_VIS_L) && (vsp_n < V_VIS_L);
            line_q     <= line_n;
            frame_q    <= frame_n;
`ifdef VGA_SYNC_PIXEL_DIV_EN
            pix_q      <= ~pix_q;
`else
            pix_q      <= 1'b1;
`endif
        end
    end

    assign vga.hsp         = hsp_q;
    assign vga.vsp         = vsp_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = video_on_q;
    assign vga.pix_tick    = pix_q;
    assign vga.line_start  = line_q;
    assign vga.frame_start = frame_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
`timescale 1ns/1ps
module tb_vga_sync_gen;

`ifdef VGA_SYNC_PIXEL_DIV_EN
    localparam int S = 2;   // clks per pixel advance
`else
    localparam int S = 1;
`endif
    localparam int WAIT_BUDGET = 40000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_a = 1'b0;
    logic rst_n_b = 1'b0;

    vga_sync_gen_if if_a();
    vga_sync_gen_if if_b();

    // Full 640x480 geometry.
    vga_sync_gen dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .vga   (if_a)
    );

    // Shrunken geometry (16x12 total) so vertical sync and frame wrap are
    // reachable in a short run. hsync low 10..12, vsync low 8..9,
    // visible h<8, v<6, frame = 192 advances.
    vga_sync_gen #(
        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .vga   (if_b)
    );

    // Clk count since reset release (0 while in reset).
    int t_a = 0;
    int t_b = 0;
    always @(posedge clk) t_a <= rst_n_a ? t_a + 1 : 0;
    always @(posedge clk) t_b <= rst_n_b ? t_b + 1 : 0;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [19:0] t;
        logic [9:0]  hsp;
        logic [9:0]  vsp;
        logic        hsync;
        logic        vsync;
        logic        video_on;
        logic        pix_tick;
        logic        line_start;
        logic        frame_start;
    } exp_t;

    exp_t exp_a_q[$];
    exp_t exp_b_q[$];

    int checks = 0;
    int errors = 0;
    logic done_a = 1'b0;
    logic done_b = 1'b0;

    function automatic logic exp_pix(int t);
        if (t == 0) return 1'b0;
`ifdef VGA_SYNC_PIXEL_DIV_EN
        return t[0];
`else
        return 1'b1;
`endif
    endfunction

    task automatic push(input bit sel, input int t, input int h, input int v,
                        input logic hs, input logic vs, input logic vo,
                        input logic ls, input logic fs);
        exp_t e;
        e.t           = 20'(t);
        e.hsp         = 10'(h);
        e.vsp         = 10'(v);
        e.hsync       = hs;
        e.vsync       = vs;
        e.video_on    = vo;
        e.pix_tick    = exp_pix(t);
        e.line_start  = ls;
        e.frame_start = fs;
        if (sel) exp_b_q.push_back(e);
        else     exp_a_q.push_back(e);
    endtask

    task automatic chk(input string tag, input int t, input string fld,
                       input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d %s: got %0d expected %0d", tag, t, fld, got, exp);
        end
    endtask

    task automatic compare(input string tag, input exp_t e,
                           input logic [9:0] h, input logic [9:0] v,
                           input logic hs, input logic vs, input logic vo,
                           input logic pt, input logic ls, input logic fs);
        chk(tag, int'(e.t), "hsp", h, e.hsp);
        chk(tag, int'(e.t), "vsp", v, e.vsp);
        chk(tag, int'(e.t), "hsync", 10'(hs), 10'(e.hsync));
        chk(tag, int'(e.t), "vsync", 10'(vs), 10'(e.vsync));
        chk(tag, int'(e.t), "video_on", 10'(vo), 10'(e.video_on));
        chk(tag, int'(e.t), "pix_tick", 10'(pt), 10'(e.pix_tick));
        chk(tag, int'(e.t), "line_start", 10'(ls), 10'(e.line_start));
        chk(tag, int'(e.t), "frame_start", 10'(fs), 10'(e.frame_start));
    endtask

    // Monitors: sample away from the active edge and pop the expectation
    // whose clk index has come up.
    always @(negedge clk) begin
        exp_t e;
        if (exp_a_q.size() > 0 && exp_a_q[0].t == 20'(t_a)) begin
            e = exp_a_q.pop_front();
            compare("a", e, if_a.hsp, if_a.vsp, if_a.hsync, if_a.vsync,
                    if_a.video_on, if_a.pix_tick, if_a.line_start, if_a.frame_start);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_b_q.size() > 0 && exp_b_q[0].t == 20'(t_b)) begin
            e = exp_b_q.pop_front();
            compare("b", e, if_b.hsp, if_b.vsp, if_b.hsync, if_b.vsync,
                    if_b.video_on, if_b.pix_tick, if_b.line_start, if_b.frame_start);
        end
    end

    // ---------------- driver: full geometry ----------------
    initial begin : stim_a
        // Power-up reset, then run to an arbitrary position.
        rst_n_a = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n_a = 1'b1;
        repeat (37) @(negedge clk);
        // Reset held for 3 edges from mid-line.
        rst_n_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push(0, 0, 0, 0, 1, 1, 1, 0, 0);
        // Cadence after release.
`ifdef VGA_SYNC_PIXEL_DIV_EN
        push(0, 1, 0, 0, 1, 1, 1, 0, 0);
        push(0, 2, 1, 0, 1, 1, 1, 0, 0);
        push(0, 3, 1, 0, 1, 1, 1, 0, 0);
        push(0, 4, 2, 0, 1, 1, 1, 0, 0);
`else
        push(0, 1, 1, 0, 1, 1, 1, 0, 0);
        push(0, 2, 2, 0, 1, 1, 1, 0, 0);
        push(0, 3, 3, 0, 1, 1, 1, 0, 0);
`endif
        // Horizontal decode on line 0.
        push(0, 639 * S, 639, 0, 1, 1, 1, 0, 0);
        push(0, 640 * S, 640, 0, 1, 1, 0, 0, 0);
        push(0, 655 * S, 655, 0, 1, 1, 0, 0, 0);
        push(0, 656 * S, 656, 0, 0, 1, 0, 0, 0);
        push(0, 751 * S, 751, 0, 0, 1, 0, 0, 0);
        push(0, 752 * S, 752, 0, 1, 1, 0, 0, 0);
        // First line wrap.
        push(0, 799 * S, 799, 0, 1, 1, 0, 0, 0);
        push(0, 800 * S, 0, 1, 1, 1, 1, 1, 0);
        push(0, 800 * S + 1, (S == 2) ? 0 : 1, 1, 1, 1, 1, 0, 0);
        // Line wrap (799,10) -> (0,11).
        push(0, 8799 * S, 799, 10, 1, 1, 0, 0, 0);
        push(0, 8800 * S, 0, 11, 1, 1, 1, 1, 0);
        push(0, 8800 * S + 1, (S == 2) ? 0 : 1, 11, 1, 1, 1, 0, 0);
        @(negedge clk) rst_n_a = 1'b1;
        for (int i = 0; i < WAIT_BUDGET && exp_a_q.size() > 0; i++) @(negedge clk);
        done_a = 1'b1;
    end

    // ---------------- driver: shrunken geometry ----------------
    initial begin : stim_b
        int i;
        rst_n_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push(1, 0, 0, 0, 1, 1, 1, 0, 0);
        // Vertical decode.
        push(1, 127 * S, 15, 7, 1, 1, 0, 0, 0);
        push(1, 133 * S, 5, 8, 1, 0, 0, 0, 0);
        push(1, 155 * S, 11, 9, 0, 0, 0, 0, 0);
        push(1, 160 * S, 0, 10, 1, 1, 0, 1, 0);
        // Frame wrap (15,11) -> (0,0), then the next one 192 advances later.
        push(1, 191 * S, 15, 11, 1, 1, 0, 0, 0);
        push(1, 192 * S, 0, 0, 1, 1, 1, 1, 1);
        push(1, 192 * S + 1, (S == 2) ? 0 : 1, 0, 1, 1, 1, 0, 0);
        push(1, 383 * S, 15, 11, 1, 1, 0, 0, 0);
        push(1, 384 * S, 0, 0, 1, 1, 1, 1, 1);
        push(1, 384 * S + 1, (S == 2) ? 0 : 1, 0, 1, 1, 1, 0, 0);
        // Position inside both sync pulses, just before a mid-frame reset.
        push(1, 540 * S, 12, 9, 0, 0, 0, 0, 0);
        @(negedge clk) rst_n_b = 1'b1;
        i = 0;
        while (i < WAIT_BUDGET && t_b != 540 * S) begin
            @(negedge clk);
            i++;
        end
        if (t_b != 540 * S) begin
            checks++;
            errors++;
            $display("FAIL b reset_point_timeout: t=%0d expected %0d", t_b, 540 * S);
        end
        // One reset edge mid-frame, then normal counting again.
        rst_n_b = 1'b0;
        push(1, 0, 0, 0, 1, 1, 1, 0, 0);
        push(1, 1, (S == 2) ? 0 : 1, 0, 1, 1, 1, 0, 0);
        push(1, 5 * S, 5, 0, 1, 1, 1, 0, 0);
        push(1, 16 * S, 0, 1, 1, 1, 1, 1, 0);
        @(negedge clk) rst_n_b = 1'b1;
        for (int k = 0; k < WAIT_BUDGET && exp_b_q.size() > 0; k++) @(negedge clk);
        done_b = 1'b1;
    end

    // ---------------- final report ----------------
    initial begin : report
        wait (done_a && done_b);
        if (exp_a_q.size() > 0) begin
            errors += exp_a_q.size();
            $display("FAIL a pending: %0d expectations never reached, expected 0", exp_a_q.size());
        end
        if (exp_b_q.size() > 0) begin
            errors += exp_b_q.size();
            $display("FAIL b pending: %0d expectations never reached, expected 0", exp_b_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
